hpdcache_mem_read_arb: RTL and testbench

Parametrised N-channel read-request arbiter and response router between the HPDcache read-side memory ports (miss read, uncached read, and future prefetch/extra requesters) and a single memory read channel. Requests are granted round-robin, tagged with the source channel index in the upper memory-ID bits, and registered once before leaving the block. Per-channel outstanding-transaction counters throttle each source. Read responses are demultiplexed back to their channel by the ID tag.

---
 rtl/hpdcache_mem_read_arb_if.sv | 83 ++++++++
 rtl/hpdcache_mem_read_arb.sv | 158 +++++++++++++++
 tb/tb_hpdcache_mem_read_arb.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_mem_read_arb_if.sv
//==============================================================================
// Module   : hpdcache_mem_read_arb_if
// Brief    : Bundle of request, memory and response channels of the HPDcache
//            memory read arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hpdcache_mem_read_arb_if #(
  parameter int unsigned NumChannels    = 3,
  parameter int unsigned AddrWidth      = 56,
  parameter int unsigned IdWidth        = 6,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned MaxOutstanding = 4
);
  localparam int unsigned c_ch_w  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned c_cnt_w = $clog2(MaxOutstanding + 1);

  // Requester side
  logic [NumChannels-1:0]                req_valid_i;
  logic [NumChannels-1:0]                req_ready_o;
  logic [NumChannels-1:0][AddrWidth-1:0] req_addr_i;
  logic [NumChannels-1:0][7:0]           req_len_i;
  logic [NumChannels-1:0][2:0]           req_size_i;
  logic [NumChannels-1:0][IdWidth-1:0]   req_id_i;
  logic [NumChannels-1:0]                req_cacheable_i;

  // Memory request side
  logic                      mem_req_valid_o;
  logic                      mem_req_ready_i;
  logic [AddrWidth-1:0]      mem_req_addr_o;
  logic [7:0]                mem_req_len_o;
  logic [2:0]                mem_req_size_o;
  logic                      mem_req_cacheable_o;
  logic [IdWidth+c_ch_w-1:0] mem_req_id_o;

  // Memory response side
  logic                      mem_resp_valid_i;
  logic                      mem_resp_ready_o;
  logic [IdWidth+c_ch_w-1:0] mem_resp_id_i;
  logic [DataWidth-1:0]      mem_resp_data_i;
  logic                      mem_resp_error_i;
  logic                      mem_resp_last_i;

  // Per-channel response side
  logic [NumChannels-1:0]              resp_valid_o;
  logic [NumChannels-1:0]              resp_ready_i;
  logic [IdWidth-1:0]                  resp_id_o;
  logic [DataWidth-1:0]                resp_data_o;
  logic                                resp_error_o;
  logic                                resp_last_o;

  logic [NumChannels-1:0][c_cnt_w-1:0] outstanding_o;
  logic                                resp_route_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_size_i, req_id_i, req_cacheable_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_size_o,
           mem_req_cacheable_o, mem_req_id_o,
    input  mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, mem_resp_error_i, mem_resp_last_i,
    output mem_resp_ready_o,
    output resp_valid_o, resp_id_o, resp_data_o, resp_error_o, resp_last_o,
    input  resp_ready_i,
    output outstanding_o, resp_route_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_size_i, req_id_i, req_cacheable_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_size_o,
           mem_req_cacheable_o, mem_req_id_o,
    output mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, mem_resp_error_i, mem_resp_last_i,
    input  mem_resp_ready_o,
    input  resp_valid_o, resp_id_o, resp_data_o, resp_error_o, resp_last_o,
    output resp_ready_i,
    input  outstanding_o, resp_route_err_o
  );
endinterface

`default_nettype wire

// File: rtl/hpdcache_mem_read_arb.sv
//==============================================================================
// Module   : hpdcache_mem_read_arb
// Brief    : Round-robin N-channel memory read arbiter with per-channel
//            outstanding throttling and ID-tag based response routing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hpdcache_mem_read_arb #(
  parameter int unsigned NumChannels    = 3,
  parameter int unsigned AddrWidth      = 56,
  parameter int unsigned IdWidth        = 6,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  hpdcache_mem_read_arb_if.slave   bus
);
  localparam int unsigned c_ch_w  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned c_cnt_w = $clog2(MaxOutstanding + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MaxOutstanding);
  localparam logic [c_ch_w:0]    c_num_ch  = (c_ch_w + 1)'(NumChannels);

  logic [NumChannels-1:0]              w_elig;
  logic [NumChannels-1:0]              w_inc;
  logic [NumChannels-1:0]              w_dec;
  logic [NumChannels-1:0]              w_req_ready;
  logic [NumChannels-1:0]              w_resp_valid;
  logic                                w_found;
  logic                                w_gnt;
  logic [c_ch_w-1:0]                   w_gnt_idx;
  logic [c_ch_w-1:0]                   w_tag;
  logic                                w_tag_ok;
  logic                                w_sel_ready;
  logic                                w_resp_ready;

  logic                                r_mem_valid;
  logic [AddrWidth-1:0]                r_mem_addr;
  logic [7:0]                          r_mem_len;
  logic [2:0]                          r_mem_size;
  logic                                r_mem_cacheable;
  logic [IdWidth+c_ch_w-1:0]           r_mem_id;
  logic [c_ch_w-1:0]                   r_rr;
  logic [NumChannels-1:0][c_cnt_w-1:0] r_cnt;
  logic                                r_route_err;

  // Two passes give round-robin order starting just after the last grant.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int j = 0; j < NumChannels; j++) begin
      if (!w_found && w_elig[j] && (c_ch_w'(j) > r_rr)) begin
        w_found   = 1'b1;
        w_gnt_idx = c_ch_w'(j);
      end
    end
    for (int j = 0; j < NumChannels; j++) begin
      if (!w_found && w_elig[j] && (c_ch_w'(j) <= r_rr)) begin
        w_found   = 1'b1;
        w_gnt_idx = c_ch_w'(j);
      end
    end
  end

  assign w_gnt = w_found && (!r_mem_valid || bus.mem_req_ready_i);

  always_comb begin
    w_req_ready = '0;
    for (int j = 0; j < NumChannels; j++) begin
      w_req_ready[j] = w_gnt && (w_gnt_idx == c_ch_w'(j));
    end
  end

  // Response demux: unknown tags are sunk so the memory side never stalls.
  assign w_tag    = bus.mem_resp_id_i[IdWidth +: c_ch_w];
  assign w_tag_ok = ({1'b0, w_tag} < c_num_ch);

  always_comb begin
    w_resp_valid = '0;
    w_sel_ready  = 1'b0;
    for (int j = 0; j < NumChannels; j++) begin
      if (w_tag == c_ch_w'(j)) begin
        w_resp_valid[j] = bus.mem_resp_valid_i;
        w_sel_ready     = bus.resp_ready_i[j];
      end
    end
  end

  assign w_resp_ready = w_tag_ok ? w_sel_ready : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem_valid     <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_len       <= '0;
      r_mem_size      <= '0;
      r_mem_cacheable <= 1'b0;
      r_mem_id        <= '0;
      r_rr            <= c_ch_w'(NumChannels - 1);
      r_route_err     <= 1'b0;
    end else begin
      r_route_err <= bus.mem_resp_valid_i && !w_tag_ok;
      if (w_gnt) begin
        r_mem_valid     <= 1'b1;
        r_mem_addr      <= bus.req_addr_i[w_gnt_idx];
        r_mem_len       <= bus.req_len_i[w_gnt_idx];
        r_mem_size      <= bus.req_size_i[w_gnt_idx];
        r_mem_cacheable <= bus.req_cacheable_i[w_gnt_idx];
        r_mem_id        <= {w_gnt_idx, bus.req_id_i[w_gnt_idx]};
        r_rr            <= w_gnt_idx;
      end else if (bus.mem_req_ready_i) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    assign w_elig[i] = bus.req_valid_i[i] && (r_cnt[i] < c_max_cnt);
    assign w_inc[i]  = w_gnt && (w_gnt_idx == c_ch_w'(i));
    assign w_dec[i]  = bus.mem_resp_valid_i && w_resp_ready && bus.mem_resp_last_i &&
                       w_tag_ok && (w_tag == c_ch_w'(i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end

`ifndef SYNTHESIS
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)));
`endif
  end

  assign bus.req_ready_o         = w_req_ready;
  assign bus.mem_req_valid_o     = r_mem_valid;
  assign bus.mem_req_addr_o      = r_mem_addr;
  assign bus.mem_req_len_o       = r_mem_len;
  assign bus.mem_req_size_o      = r_mem_size;
  assign bus.mem_req_cacheable_o = r_mem_cacheable;
  assign bus.mem_req_id_o        = r_mem_id;
  assign bus.mem_resp_ready_o    = w_resp_ready;
  assign bus.resp_valid_o        = w_resp_valid;
  assign bus.resp_id_o           = bus.mem_resp_id_i[IdWidth-1:0];
  assign bus.resp_data_o         = bus.mem_resp_data_i;
  assign bus.resp_error_o        = bus.mem_resp_error_i;
  assign bus.resp_last_o         = bus.mem_resp_last_i;
  assign bus.outstanding_o       = r_cnt;
  assign bus.resp_route_err_o    = r_route_err;

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_mem_read_arb.sv
//==============================================================================
// Module   : tb_hpdcache_mem_read_arb
// Brief    : Directed vector bench for hpdcache_mem_read_arb (3 channels).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hpdcache_mem_read_arb;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hpdcache_mem_read_arb_if #(
    .NumChannels(3), .AddrWidth(56), .IdWidth(6), .DataWidth(512), .MaxOutstanding(4)
  ) bus ();

  hpdcache_mem_read_arb #(
    .NumChannels(3), .AddrWidth(56), .IdWidth(6), .DataWidth(512), .MaxOutstanding(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [2:0] req_valid;
    logic [2:0] exp_rdy;
    logic       exp_mv;
    logic [7:0] exp_id;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid_i      = '0;
    bus.req_addr_i       = '0;
    bus.req_len_i        = '0;
    bus.req_size_i       = '0;
    bus.req_id_i         = '0;
    bus.req_cacheable_i  = '0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_id_i    = '0;
    bus.mem_resp_data_i  = '0;
    bus.mem_resp_error_i = 1'b0;
    bus.mem_resp_last_i  = 1'b0;
    bus.resp_ready_i     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] rpat;
    logic [6:0] lpat;

    tbl[0]  = '{3'b111, 3'b001, 1'b0, 8'h00};
    tbl[1]  = '{3'b111, 3'b010, 1'b1, 8'h10};
    tbl[2]  = '{3'b111, 3'b100, 1'b1, 8'h51};
    tbl[3]  = '{3'b111, 3'b001, 1'b1, 8'h92};
    tbl[4]  = '{3'b111, 3'b010, 1'b1, 8'h10};
    tbl[5]  = '{3'b111, 3'b100, 1'b1, 8'h51};
    tbl[6]  = '{3'b111, 3'b001, 1'b1, 8'h92};
    tbl[7]  = '{3'b111, 3'b010, 1'b1, 8'h10};
    tbl[8]  = '{3'b111, 3'b100, 1'b1, 8'h51};
    tbl[9]  = '{3'b111, 3'b001, 1'b1, 8'h92};
    tbl[10] = '{3'b111, 3'b010, 1'b1, 8'h10};
    tbl[11] = '{3'b111, 3'b100, 1'b1, 8'h51};
    tbl[12] = '{3'b111, 3'b000, 1'b1, 8'h92};
    tbl[13] = '{3'b111, 3'b000, 1'b0, 8'h00};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_mem_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("rst_mem_id", 64'(bus.mem_req_id_o), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_req_addr_o), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    chk("rst_route_err", 64'(bus.resp_route_err_o), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fill until every channel hits the outstanding limit
    bus.req_id_i[0] = 6'h10;
    bus.req_id_i[1] = 6'h11;
    bus.req_id_i[2] = 6'h12;
    bus.mem_req_ready_i = 1'b1;
    for (int k = 0; k < 14; k++) begin
      bus.req_valid_i = tbl[k].req_valid;
      #1;
      chk($sformatf("rr_req_ready[%0d]", k), 64'(bus.req_ready_o), 64'(tbl[k].exp_rdy));
      chk($sformatf("rr_mem_valid[%0d]", k), 64'(bus.mem_req_valid_o), 64'(tbl[k].exp_mv));
      if (tbl[k].exp_mv)
        chk($sformatf("rr_mem_id[%0d]", k), 64'(bus.mem_req_id_o), 64'(tbl[k].exp_id));
      tick();
    end
    chk("rr_outstanding_444", 64'(bus.outstanding_o), 64'(9'o444));

    // Single request on channel 1 and its response
    do_reset();
    bus.mem_req_ready_i    = 1'b1;
    bus.req_valid_i        = 3'b010;
    bus.req_addr_i[1]      = 56'h1000;
    bus.req_id_i[1]        = 6'h2A;
    bus.req_len_i[1]       = 8'd3;
    bus.req_size_i[1]      = 3'd6;
    bus.req_cacheable_i[1] = 1'b1;
    #1;
    chk("c1_req_ready", 64'(bus.req_ready_o), 64'b010);
    tick();
    bus.req_valid_i = '0;
    #1;
    chk("c1_mem_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("c1_mem_id", 64'(bus.mem_req_id_o), 64'h6A);
    chk("c1_mem_addr", 64'(bus.mem_req_addr_o), 64'h1000);
    chk("c1_mem_len", 64'(bus.mem_req_len_o), 64'd3);
    chk("c1_mem_size", 64'(bus.mem_req_size_o), 64'd6);
    chk("c1_mem_cacheable", 64'(bus.mem_req_cacheable_o), 64'd1);
    chk("c1_outstanding", 64'(bus.outstanding_o), 64'h08);
    tick();
    chk("c1_mem_valid_drop", 64'(bus.mem_req_valid_o), 64'd0);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_id_i    = 8'h6A;
    bus.mem_resp_data_i  = {8{64'hDEAD_BEEF_0000_0001}};
    bus.mem_resp_error_i = 1'b1;
    bus.mem_resp_last_i  = 1'b1;
    bus.resp_ready_i     = 3'b010;
    #1;
    chk("c1_resp_valid", 64'(bus.resp_valid_o), 64'b010);
    chk("c1_resp_id", 64'(bus.resp_id_o), 64'h2A);
    chk("c1_resp_data", bus.resp_data_o[511:448], 64'hDEAD_BEEF_0000_0001);
    chk("c1_resp_error", 64'(bus.resp_error_o), 64'd1);
    chk("c1_resp_last", 64'(bus.resp_last_o), 64'd1);
    chk("c1_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd1);
    tick();
    bus.mem_resp_valid_i = 1'b0;
    #1;
    chk("c1_outstanding_done", 64'(bus.outstanding_o), 64'd0);

    // Memory back-pressure holds the output register and blocks grants
    do_reset();
    bus.req_valid_i   = 3'b001;
    bus.req_id_i[0]   = 6'h01;
    bus.req_addr_i[0] = 56'hA0;
    #1;
    chk("bp_first_grant", 64'(bus.req_ready_o), 64'b001);
    tick();
    bus.req_id_i[0]   = 6'h02;
    bus.req_addr_i[0] = 56'hB0;
    bus.req_id_i[2]   = 6'h03;
    bus.req_valid_i   = 3'b101;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_req_ready[%0d]", c), 64'(bus.req_ready_o), 64'b000);
      chk($sformatf("bp_mem_valid[%0d]", c), 64'(bus.mem_req_valid_o), 64'd1);
      chk($sformatf("bp_mem_id[%0d]", c), 64'(bus.mem_req_id_o), 64'h01);
      chk($sformatf("bp_mem_addr[%0d]", c), 64'(bus.mem_req_addr_o), 64'hA0);
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk("bp_release_grant", 64'(bus.req_ready_o), 64'b100);
    tick();
    bus.req_valid_i = '0;
    #1;
    chk("bp_next_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("bp_next_id", 64'(bus.mem_req_id_o), 64'h83);
    chk("bp_outstanding", 64'(bus.outstanding_o), 64'h41);

    // Channel 0 at its limit: last beat and request in flight together
    do_reset();
    bus.mem_req_ready_i = 1'b1;
    bus.req_valid_i     = 3'b001;
    bus.req_id_i[0]     = 6'h05;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("lim_grant[%0d]", c), 64'(bus.req_ready_o), 64'b001);
      tick();
    end
    #1;
    chk("lim_stalled", 64'(bus.req_ready_o), 64'b000);
    chk("lim_cnt4", 64'(bus.outstanding_o), 64'd4);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_id_i    = 8'h05;
    bus.mem_resp_last_i  = 1'b1;
    bus.resp_ready_i     = 3'b001;
    #1;
    chk("lim_resp_ready", 64'(bus.mem_resp_ready_o), 64'd1);
    chk("lim_no_grant_at4", 64'(bus.req_ready_o), 64'b000);
    tick();
    #1;
    chk("lim_cnt3", 64'(bus.outstanding_o), 64'd3);
    chk("lim_overlap_grant", 64'(bus.req_ready_o), 64'b001);
    tick();
    bus.mem_resp_valid_i = 1'b0;
    #1;
    chk("lim_overlap_cnt", 64'(bus.outstanding_o), 64'd3);
    chk("lim_regrant", 64'(bus.req_ready_o), 64'b001);
    tick();
    chk("lim_cnt4_again", 64'(bus.outstanding_o), 64'd4);
    chk("lim_stalled_again", 64'(bus.req_ready_o), 64'b000);

    // Four-beat response to channel 2 with toggling ready
    do_reset();
    bus.mem_req_ready_i = 1'b1;
    bus.req_valid_i     = 3'b100;
    bus.req_id_i[2]     = 6'h07;
    #1;
    chk("burst_grant", 64'(bus.req_ready_o), 64'b100);
    tick();
    bus.req_valid_i = '0;
    rpat = 7'b1010101;
    lpat = 7'b1100000;
    for (int c = 0; c < 7; c++) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_id_i    = 8'h87;
      bus.mem_resp_last_i  = lpat[c];
      bus.resp_ready_i     = {rpat[c], 2'b11};
      #1;
      chk($sformatf("burst_ready[%0d]", c), 64'(bus.mem_resp_ready_o), 64'(rpat[c]));
      chk($sformatf("burst_valid[%0d]", c), 64'(bus.resp_valid_o), 64'b100);
      chk($sformatf("burst_cnt[%0d]", c), 64'(bus.outstanding_o), 64'h40);
      tick();
    end
    bus.mem_resp_valid_i = 1'b0;
    #1;
    chk("burst_cnt_done", 64'(bus.outstanding_o), 64'd0);

    // Unmapped tag 3 is sunk and flagged
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_id_i    = 8'hC5;
    bus.mem_resp_last_i  = 1'b1;
    bus.resp_ready_i     = 3'b000;
    #1;
    chk("bad_tag_ready", 64'(bus.mem_resp_ready_o), 64'd1);
    chk("bad_tag_no_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("bad_tag_err_before", 64'(bus.resp_route_err_o), 64'd0);
    tick();
    bus.mem_resp_valid_i = 1'b0;
    #1;
    chk("bad_tag_err_pulse", 64'(bus.resp_route_err_o), 64'd1);
    chk("bad_tag_cnt", 64'(bus.outstanding_o), 64'd0);
    tick();
    chk("bad_tag_err_clear", 64'(bus.resp_route_err_o), 64'd0);

    // Asynchronous reset with a request held in the output register
    bus.req_valid_i = 3'b001;
    bus.req_id_i[0] = 6'h09;
    bus.mem_req_ready_i = 1'b0;
    tick();
    chk("ar_mem_valid", 64'(bus.mem_req_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_valid_drop", 64'(bus.mem_req_valid_o), 64'd0);
    chk("ar_mem_id", 64'(bus.mem_req_id_o), 64'd0);
    chk("ar_outstanding", 64'(bus.outstanding_o), 64'd0);
    idle();
    #1;
    chk("ar_req_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1);
  end

endmodule

`default_nettype wire
